// File: rtl/matmul_stream_engine.sv
// -----------------------------------------------------------------------------
// matmul_stream_engine
//
// Streaming signed matrix multiplier that acts as a bus master on a shared
// single-port RAM. The host places a config word, the operands and a start
// request in RAM. The engine then computes C = A * B one element at a time.
// Each element is accumulated in a single signed MAC, and the engine writes C
// and a final status word back to RAM. No matrix is stored on chip.
//
// RAM map: addr0 config {M[31:22], K[21:12], N[11:2]}.
//          addr1 status {start[31], aborted[3], error[2], done[1], busy[0]}.
//          A is row-major from addr 2, B is row-major from 2+M*K,
//          and C is row-major from RES_BASE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ram_rdata  RAM read data (reflects ram_addr registered one edge earlier)
//   abort      level; stops the current job, which ends with status 0xE
//   ram_addr   registered RAM address
//   ram_wdata  registered RAM write data
//   ram_we     registered RAM write enable
//   busy       high from job accept to the final status write
//   done_pulse one-cycle pulse during the final status write
//
// Build option: define MATMUL_SATURATE_EN to saturate each C element to the
// signed DW range. Without it, each element is the low DW bits of the
// accumulator (wrap-around).
// -----------------------------------------------------------------------------
module matmul_stream_engine #(
  parameter int DW       = 32,
  parameter int AW       = 12,
  parameter int DIM_W    = 10,
  parameter int RES_BASE = 3072,
  parameter int ACC_W    = 2*DW + DIM_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ram_rdata,
  input  logic          abort,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          busy,
  output logic          done_pulse
);

  // Wide enough for 2+M*K+K*N and for RES_BASE+M*N compared against 2^AW.
  localparam int CW = ((2*DIM_W > AW) ? 2*DIM_W : AW) + 2;

  typedef enum logic [2:0] {IDLE, CONF, CHECK, FETCH, WRITE, STAT} state_t;

  state_t                   state;
  logic [DIM_W-1:0]         m_dim, k_dim, n_dim;
  logic [DIM_W-1:0]         i_idx, j_idx, k_idx;
  logic [AW-1:0]            a_row, a_ptr, b_base, b_col, b_ptr, c_ptr;
  logic signed [DW-1:0]     a_reg, b_reg;
  logic signed [ACC_W-1:0]  acc;
  logic                     ph, issuing, mac_pend, cfg_bad;

  // Config decode and range check are done on the config word while it is on
  // ram_rdata. CHECK can then act on the result at once, and its busy-status
  // write is issued only for a valid job.
  logic [DIM_W-1:0] cfg_m, cfg_k, cfg_n;
  logic [CW-1:0]    cfg_mk, cfg_kn, cfg_mn;
  logic             cfg_err;

  assign cfg_m = ram_rdata[31 -: DIM_W];
  assign cfg_k = ram_rdata[21 -: DIM_W];
  assign cfg_n = ram_rdata[11 -: DIM_W];

  always_comb begin
    cfg_mk  = CW'(cfg_m) * CW'(cfg_k);
    cfg_kn  = CW'(cfg_k) * CW'(cfg_n);
    cfg_mn  = CW'(cfg_m) * CW'(cfg_n);
    cfg_err = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0) ||
              (CW'(2) + cfg_mk + cfg_kn > CW'(RES_BASE)) ||
              (CW'(RES_BASE) + cfg_mn > (CW'(1) << AW));
  end

  // Full-precision signed product. The accumulator is wide enough that K
  // terms can never overflow it.
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [DW-1:0]           res_word;

  assign prod     = a_reg * b_reg;
  assign prod_ext = ACC_W'(prod);

  // Reduce the accumulator to one RAM word. The value fits exactly when all
  // bits from the sign bit down to bit DW-1 agree.
`ifdef MATMUL_SATURATE_EN
  always_comb begin
    res_word = acc[DW-1:0];
    if (!((&acc[ACC_W-1:DW-1]) || !(|acc[ACC_W-1:DW-1])))
      res_word = acc[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  always_comb begin
    res_word = acc[DW-1:0];
  end
`endif

  // Main controller: one state register plus all datapath registers.
  // Each term takes two read slots (A then B), and the product is accumulated
  // one cycle after B is captured. Terms overlap with the next A fetch, so K
  // terms plus drain take 2K+2 cycles before WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ram_addr   <= AW'(1);
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      acc        <= '0;
      m_dim <= '0;  k_dim <= '0;  n_dim <= '0;
      i_idx <= '0;  j_idx <= '0;  k_idx <= '0;
      a_row <= '0;  a_ptr <= '0;  b_base <= '0;
      b_col <= '0;  b_ptr <= '0;  c_ptr <= '0;
      a_reg <= '0;  b_reg <= '0;
      ph <= 1'b0;  issuing <= 1'b0;  mac_pend <= 1'b0;  cfg_bad <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_rdata[31]) begin
            state    <= CONF;
            busy     <= 1'b1;
            ram_addr <= '0;
          end
        end
        CONF: begin
          m_dim     <= cfg_m;
          k_dim     <= cfg_k;
          n_dim     <= cfg_n;
          b_base    <= AW'(CW'(2) + cfg_mk);
          cfg_bad   <= cfg_err;
          ram_addr  <= AW'(1);
          ram_wdata <= DW'(1);
          ram_we    <= !cfg_err;
          state     <= CHECK;
        end
        CHECK: begin
          if (cfg_bad) begin
            state      <= STAT;
            ram_addr   <= AW'(1);
            ram_wdata  <= DW'(6);
            ram_we     <= 1'b1;
            done_pulse <= 1'b1;
          end else begin
            state    <= FETCH;
            ram_we   <= 1'b0;
            ram_addr <= AW'(2);
            a_row    <= AW'(2);
            a_ptr    <= AW'(2);
            b_col    <= b_base;
            b_ptr    <= b_base;
            c_ptr    <= AW'(RES_BASE);
            i_idx <= '0;  j_idx <= '0;  k_idx <= '0;
            acc <= '0;  ph <= 1'b0;  issuing <= 1'b1;  mac_pend <= 1'b0;
          end
        end
        FETCH: begin
          if (mac_pend) begin
            acc      <= acc + prod_ext;
            mac_pend <= 1'b0;
          end
          if (issuing) begin
            if (!ph) begin
              a_reg    <= ram_rdata;
              ram_addr <= b_ptr;
              ph       <= 1'b1;
            end else begin
              b_reg    <= ram_rdata;
              mac_pend <= 1'b1;
              ph       <= 1'b0;
              if (j_idx == k_dim - 1'b1) begin
                issuing <= 1'b0;
              end else begin
                j_idx    <= j_idx + 1'b1;
                a_ptr    <= a_ptr + 1'b1;
                ram_addr <= a_ptr + 1'b1;
                b_ptr    <= b_ptr + AW'(n_dim);
              end
            end
          end else if (!mac_pend) begin
            state     <= WRITE;
            ram_we    <= 1'b1;
            ram_addr  <= c_ptr;
            ram_wdata <= res_word;
          end
        end
        WRITE: begin
          acc    <= '0;
          ram_we <= 1'b0;
          if ((k_idx == n_dim - 1'b1) && (i_idx == m_dim - 1'b1)) begin
            state      <= STAT;
            ram_addr   <= AW'(1);
            ram_wdata  <= DW'(2);
            ram_we     <= 1'b1;
            done_pulse <= 1'b1;
          end else begin
            state   <= FETCH;
            c_ptr   <= c_ptr + 1'b1;
            j_idx   <= '0;
            ph      <= 1'b0;
            issuing <= 1'b1;
            if (k_idx == n_dim - 1'b1) begin
              k_idx    <= '0;
              i_idx    <= i_idx + 1'b1;
              a_row    <= a_row + AW'(k_dim);
              a_ptr    <= a_row + AW'(k_dim);
              ram_addr <= a_row + AW'(k_dim);
              b_col    <= b_base;
              b_ptr    <= b_base;
            end else begin
              k_idx    <= k_idx + 1'b1;
              a_ptr    <= a_row;
              ram_addr <= a_row;
              b_col    <= b_col + 1'b1;
              b_ptr    <= b_col + 1'b1;
            end
          end
        end
        STAT: begin
          state      <= IDLE;
          ram_we     <= 1'b0;
          ram_addr   <= AW'(1);
          done_pulse <= 1'b0;
          busy       <= 1'b0;
          acc        <= '0;
        end
        default: state <= IDLE;
      endcase

      // Abort wins over every normal transition. A WRITE already on the bus
      // this cycle still lands at this edge, and STAT follows with 0xE.
      if (abort && (state == CONF || state == CHECK || state == FETCH || state == WRITE)) begin
        state      <= STAT;
        ram_addr   <= AW'(1);
        ram_wdata  <= DW'(14);
        ram_we     <= 1'b1;
        done_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_matmul_stream_engine
//
// Directed bench for matmul_stream_engine. A behavioural RAM sits beside the
// DUT, and host writes to it are made through the same RAM process. A monitor
// counts result writes, done pulses and busy cycles for each job. Expected
// values are hand-computed products.
// -----------------------------------------------------------------------------
module tb_matmul_stream_engine;

  localparam int DW       = 32;
  localparam int AW       = 12;
  localparam int RES_BASE = 3072;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          abort = 1'b0;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, busy, done_pulse;

  logic [31:0]   mem [0:4095];
  logic          h_we = 1'b0, h_clr = 1'b0, h_wipe = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [31:0]   h_data = '0;

  int wr_c_cnt, max_c, done_cnt, busy_cnt;
  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp22 [4] = '{32'd19, 32'd22, 32'd43, 32'd50};

  matmul_stream_engine #(.DW(DW), .AW(AW), .DIM_W(10), .RES_BASE(RES_BASE)) dut (
    .clk(clk), .rst(rst), .ram_rdata(ram_rdata), .abort(abort),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .busy(busy), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  // RAM read data follows the registered address.
  assign ram_rdata = mem[ram_addr];

  // RAM writes (DUT and host) and the per-job activity monitor.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (h_we) mem[h_addr] <= h_data;
    if (h_wipe) for (int a = RES_BASE; a < RES_BASE + 8; a++) mem[a] <= 32'hDEAD_BEEF;
    if (h_clr) begin
      wr_c_cnt <= 0; max_c <= 0; done_cnt <= 0; busy_cnt <= 0;
    end else begin
      if (ram_we && int'(ram_addr) >= RES_BASE) begin
        wr_c_cnt <= wr_c_cnt + 1;
        if (int'(ram_addr) > max_c) max_c <= int'(ram_addr);
      end
      if (done_pulse) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  function automatic logic [31:0] conf_word(input int m, input int k, input int n);
    return (32'(m) << 22) | (32'(k) << 12) | (32'(n) << 2);
  endfunction

  task automatic host_wr(input int a, input logic [31:0] d);
    @(negedge clk); h_we = 1'b1; h_addr = AW'(a); h_data = d;
    @(negedge clk); h_we = 1'b0;
  endtask

  task automatic wipe_c;
    @(negedge clk); h_wipe = 1'b1;
    @(negedge clk); h_wipe = 1'b0;
  endtask

  task automatic start_job;
    @(negedge clk); h_we = 1'b1; h_addr = AW'(1); h_data = 32'h8000_0000; h_clr = 1'b1;
    @(negedge clk); h_we = 1'b0; h_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (done_cnt != 0) ok = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic load_2x2x2;
    host_wr(0, conf_word(2, 2, 2));
    for (int e = 0; e < 4; e++) host_wr(2 + e, 32'(e + 1));
    for (int e = 0; e < 4; e++) host_wr(6 + e, 32'(e + 5));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    host_wr(1, 32'h0);
    repeat (2) @(negedge clk);
    compared++; if (ram_addr !== 12'd1) begin mismatched++; $display("[TB] FAIL reset ram_addr: got %0d want 1", ram_addr); end
    compared++; if (ram_wdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset ram_wdata: got %h want 0", ram_wdata); end
    compared++; if (ram_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset ram_we: got %b want 0", ram_we); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    compared++; if (done_pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL reset done_pulse: got %b want 0", done_pulse); end
    rst = 1'b0;
  endtask

  // [1 2;3 4]*[5 6;7 8] = [19 22;43 50]; busy: CONF+CHECK+4*(6+1)+STAT = 31.
  task automatic test_2x2x2;
    bit ok;
    load_2x2x2();
    wipe_c();
    start_job();
    wait_done(300, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL 2x2x2 timeout: done=%b want 1", ok); end
    for (int e = 0; e < 4; e++) begin
      compared++;
      if (mem[RES_BASE + e] !== exp22[e]) begin
        mismatched++; $display("[TB] FAIL 2x2x2 C[%0d]: got %h want %h", e, mem[RES_BASE + e], exp22[e]);
      end
    end
    compared++; if (mem[1] !== 32'h2) begin mismatched++; $display("[TB] FAIL 2x2x2 status: got %h want 2", mem[1]); end
    compared++; if (done_cnt !== 1) begin mismatched++; $display("[TB] FAIL 2x2x2 done pulses: got %0d want 1", done_cnt); end
    compared++; if (busy_cnt !== 31) begin mismatched++; $display("[TB] FAIL 2x2x2 busy cycles: got %0d want 31", busy_cnt); end
    compared++; if (wr_c_cnt !== 4) begin mismatched++; $display("[TB] FAIL 2x2x2 C writes: got %0d want 4", wr_c_cnt); end
  endtask

  // (-1*4)+(2*-5)+(-3*6) = -32; busy: 2+(2*3+2+1)+1 = 12.
  task automatic test_signed;
    bit ok;
    host_wr(0, conf_word(1, 3, 1));
    host_wr(2, -32'sd1); host_wr(3, 32'sd2); host_wr(4, -32'sd3);
    host_wr(5, 32'sd4);  host_wr(6, -32'sd5); host_wr(7, 32'sd6);
    wipe_c();
    start_job();
    wait_done(200, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL signed timeout: done=%b want 1", ok); end
    compared++; if (mem[RES_BASE] !== 32'hFFFF_FFE0) begin mismatched++; $display("[TB] FAIL signed C[0]: got %h want FFFFFFE0", mem[RES_BASE]); end
    compared++; if (mem[1] !== 32'h2) begin mismatched++; $display("[TB] FAIL signed status: got %h want 2", mem[1]); end
    compared++; if (busy_cnt !== 12) begin mismatched++; $display("[TB] FAIL signed busy cycles: got %0d want 12", busy_cnt); end
  endtask

  task automatic test_zero_dim;
    bit ok;
    host_wr(0, conf_word(2, 0, 2));
    wipe_c();
    start_job();
    wait_done(100, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL zerodim timeout: done=%b want 1", ok); end
    compared++; if (mem[1] !== 32'h6) begin mismatched++; $display("[TB] FAIL zerodim status: got %h want 6", mem[1]); end
    compared++; if (wr_c_cnt !== 0) begin mismatched++; $display("[TB] FAIL zerodim C writes: got %0d want 0", wr_c_cnt); end
    compared++; if (busy_cnt > 3 || busy_cnt == 0) begin mismatched++; $display("[TB] FAIL zerodim busy cycles: got %0d want 1..3", busy_cnt); end
    compared++; if (done_cnt !== 1) begin mismatched++; $display("[TB] FAIL zerodim done pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_overflow;
    bit ok;
    logic [31:0] want;
`ifdef MATMUL_SATURATE_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'hFFFF_FFFE;
`endif
    host_wr(0, conf_word(1, 1, 1));
    host_wr(2, 32'h7FFF_FFFF); host_wr(3, 32'd2);
    wipe_c();
    start_job();
    wait_done(100, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL overflow timeout: done=%b want 1", ok); end
    compared++; if (mem[RES_BASE] !== want) begin mismatched++; $display("[TB] FAIL overflow C[0]: got %h want %h", mem[RES_BASE], want); end
    compared++; if (busy_cnt !== 8) begin mismatched++; $display("[TB] FAIL overflow busy cycles: got %0d want 8", busy_cnt); end
  endtask

  task automatic test_abort;
    bit ok, seen;
    load_2x2x2();
    wipe_c();
    start_job();
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (ram_we && int'(ram_addr) == RES_BASE) seen = 1'b1;
    end
    compared++; if (seen !== 1'b1) begin mismatched++; $display("[TB] FAIL abort first C write: seen=%b want 1", seen); end
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(100, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL abort timeout: done=%b want 1", ok); end
    compared++; if (mem[RES_BASE] !== 32'd19) begin mismatched++; $display("[TB] FAIL abort C[0]: got %h want 13", mem[RES_BASE]); end
    compared++; if (max_c > RES_BASE + 1) begin mismatched++; $display("[TB] FAIL abort max C addr: got %0d want <= %0d", max_c, RES_BASE + 1); end
    compared++; if (mem[1] !== 32'hE) begin mismatched++; $display("[TB] FAIL abort status: got %h want E", mem[1]); end
  endtask

  task automatic test_reset_restart;
    bit ok;
    load_2x2x2();
    start_job();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst busy: got %b want 0", busy); end
    compared++; if (ram_addr !== 12'd1) begin mismatched++; $display("[TB] FAIL midrst ram_addr: got %0d want 1", ram_addr); end
    compared++; if (ram_we !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst ram_we: got %b want 0", ram_we); end
    compared++; if (ram_wdata !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst ram_wdata: got %h want 0", ram_wdata); end
    rst = 1'b0;
    wipe_c();
    start_job();
    wait_done(300, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL restart timeout: done=%b want 1", ok); end
    for (int e = 0; e < 4; e++) begin
      compared++;
      if (mem[RES_BASE + e] !== exp22[e]) begin
        mismatched++; $display("[TB] FAIL restart C[%0d]: got %h want %h", e, mem[RES_BASE + e], exp22[e]);
      end
    end
    compared++; if (mem[1] !== 32'h2) begin mismatched++; $display("[TB] FAIL restart status: got %h want 2", mem[1]); end
  endtask

  initial begin
    test_reset();
    test_2x2x2();
    test_signed();
    test_zero_dim();
    test_overflow();
    test_abort();
    test_reset_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
